// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: turns RV32I byte-addressed loads/stores into word accesses
// on a word-indexed memory, using read-modify-write for SB/SH.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [31:0] r_respRdata;
    logic        r_respValid;
    logic        r_respErr;

    logic        w_reqErr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;
    logic [31:0] w_mergedWord;

    always_comb begin
        w_reqErr = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            w_reqErr = 1'b1;
        if (req_we && (req_funct3 == 3'b100 || req_funct3 == 3'b101))
            w_reqErr = 1'b1;
        if ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0])
            w_reqErr = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            w_reqErr = 1'b1;
        if ((req_addr >> (ADDR_W + 2)) != 32'd0)
            w_reqErr = 1'b1;
    end

    // Lane selection is little-endian: offset 0 is the least significant byte.
    always_comb begin
        w_byte = mem_q[{r_offset, 3'b000} +: 8];
        w_half = mem_q[{r_offset[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = mem_q;
        endcase
        w_mergedWord = mem_q;
        if (r_funct3[0])
            w_mergedWord[{r_offset[1], 4'b0000} +: 16] = r_wdata;
        else
            w_mergedWord[{r_offset, 3'b000} +: 8] = r_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_offset    <= 2'd0;
            r_wdata     <= 16'd0;
            r_memAddr   <= 32'd0;
            r_memWdata  <= 32'd0;
            r_respRdata <= 32'd0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
        end else begin
            r_respValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_offset  <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        r_memAddr <= 32'(req_addr[ADDR_W+1:2]);
                        if (w_reqErr) begin
                            r_state     <= RESP;
                            r_respValid <= 1'b1;
                            r_respErr   <= 1'b1;
                            r_respRdata <= 32'd0;
                        end else if (!req_we) begin
                            r_state <= READ;
                        end else if (req_funct3 == 3'b010) begin
                            r_memWdata <= req_wdata;
                            r_state    <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (r_we) begin
                        r_memWdata <= w_mergedWord;
                        r_state    <= WRITE;
                    end else begin
                        r_respRdata <= w_loadData;
                        r_respErr   <= 1'b0;
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WRITE: begin
                    r_respRdata <= 32'd0;
                    r_respErr   <= 1'b0;
                    r_respValid <= 1'b1;
                    r_state     <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write enable comes straight from the state register so it cannot glitch.
    assign mem_we     = (r_state == WRITE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;

endmodule
